// File: rtl/keycode_move_ctrl.sv
// Keycode glitch filter, walk/attack FSM paced by frame_tick, and clamped player position.
// Optional KEYCODE_DIAG_EN adds a diag port: {fcnt[5:0], state, key_q}.
module keycode_move_ctrl #(
  parameter int unsigned STABLE_CYCLES   = 16,
  parameter int unsigned ATTACK_FRAMES   = 12,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned STEP            = 1,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = 624,
  parameter int unsigned Y_MIN           = 0,
  parameter int unsigned Y_MAX           = 464,
  parameter int unsigned X_INIT          = 320,
  parameter int unsigned Y_INIT          = 240
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  keycode,
  input  logic        frame_tick,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic [1:0]  facing,
  output logic        walking,
  output logic        attack_active,
  output logic        attack_start
`ifdef KEYCODE_DIAG_EN
  ,
  output logic [15:0] diag
`endif
);

  localparam int unsigned CntW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned FcntW = 16;

  localparam logic [CntW-1:0]  CntMax   = CntW'(STABLE_CYCLES - 1);
  localparam logic [FcntW-1:0] AtkLast  = FcntW'(ATTACK_FRAMES - 1);
  localparam logic [FcntW-1:0] CoolLast = FcntW'(COOLDOWN_FRAMES - 1);

  localparam logic [10:0] Step11 = 11'(STEP);
  localparam logic [10:0] XMin11 = 11'(X_MIN);
  localparam logic [10:0] XMax11 = 11'(X_MAX);
  localparam logic [10:0] YMin11 = 11'(Y_MIN);
  localparam logic [10:0] YMax11 = 11'(Y_MAX);

  localparam logic [7:0] KeyUp    = 8'h1A;
  localparam logic [7:0] KeyDown  = 8'h16;
  localparam logic [7:0] KeyLeft  = 8'h04;
  localparam logic [7:0] KeyRight = 8'h07;
  localparam logic [7:0] KeyAtk   = 8'h2C;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWalk     = 2'd1,
    StAttack   = 2'd2,
    StCooldown = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cand_q, cand_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       key_q, key_d;
  logic [7:0]       key_prev_q;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [1:0]       facing_q, facing_d;
  logic             attack_start_q, attack_start_d;

  logic             dir_valid;
  logic [1:0]       dir;
  logic             atk_rise;

  // Saturating step toward a bound; 11-bit math so nothing wraps.
  function automatic logic [9:0] dec_clamp(logic [9:0] v, logic [10:0] lo);
    logic [10:0] ext;
    ext = {1'b0, v};
    return (ext < lo + Step11) ? lo[9:0] : 10'(ext - Step11);
  endfunction

  function automatic logic [9:0] inc_clamp(logic [9:0] v, logic [10:0] hi);
    logic [10:0] ext;
    ext = {1'b0, v};
    return (ext + Step11 > hi) ? hi[9:0] : 10'(ext + Step11);
  endfunction

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    key_d  = key_q;
    if (keycode != cand_q) begin
      cand_d = keycode;
      cnt_d  = '0;
    end else if (cnt_q == CntMax) begin
      key_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    dir_valid = 1'b1;
    dir       = 2'd0;
    case (key_q)
      KeyUp:    dir = 2'd0;
      KeyDown:  dir = 2'd1;
      KeyLeft:  dir = 2'd2;
      KeyRight: dir = 2'd3;
      default:  dir_valid = 1'b0;
    endcase
  end

  assign atk_rise = (key_q == KeyAtk) && (key_prev_q != KeyAtk);

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    x_d            = x_q;
    y_d            = y_q;
    facing_d       = facing_q;
    attack_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (atk_rise) begin
          state_d        = StAttack;
          fcnt_d         = '0;
          attack_start_d = 1'b1;
        end else if (dir_valid) begin
          state_d  = StWalk;
          fcnt_d   = '0;
          facing_d = dir;
        end
      end
      StWalk: begin
        if (atk_rise) begin
          state_d        = StAttack;
          fcnt_d         = '0;
          attack_start_d = 1'b1;
        end else if (!dir_valid) begin
          state_d = StIdle;
          fcnt_d  = '0;
        end else begin
          facing_d = dir;
          if (frame_tick) begin
            case (dir)
              2'd0:    y_d = dec_clamp(y_q, YMin11);
              2'd1:    y_d = inc_clamp(y_q, YMax11);
              2'd2:    x_d = dec_clamp(x_q, XMin11);
              default: x_d = inc_clamp(x_q, XMax11);
            endcase
          end
        end
      end
      StAttack: begin
        if (frame_tick) begin
          if (fcnt_q == AtkLast) begin
            state_d = StCooldown;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      StCooldown: begin
        if (frame_tick) begin
          if (fcnt_q == CoolLast) begin
            state_d = StIdle;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q        <= StIdle;
      cand_q         <= 8'h00;
      cnt_q          <= '0;
      key_q          <= 8'h00;
      key_prev_q     <= 8'h00;
      fcnt_q         <= '0;
      x_q            <= 10'(X_INIT);
      y_q            <= 10'(Y_INIT);
      facing_q       <= 2'd1;
      attack_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      key_q          <= key_d;
      key_prev_q     <= key_q;
      fcnt_q         <= fcnt_d;
      x_q            <= x_d;
      y_q            <= y_d;
      facing_q       <= facing_d;
      attack_start_q <= attack_start_d;
    end
  end

  assign player_x      = x_q;
  assign player_y      = y_q;
  assign facing        = facing_q;
  assign walking       = (state_q == StWalk);
  assign attack_active = (state_q == StAttack);
  assign attack_start  = attack_start_q;

`ifdef KEYCODE_DIAG_EN
  assign diag = {fcnt_q[5:0], state_q, key_q};
`endif

endmodule

// File: tb/tb_keycode_move_ctrl.sv
// Bench for keycode_move_ctrl: directed scenarios plus random keycodes/ticks against a
// run-length / countdown reference model. Define KEYCODE_DIAG_EN to also check diag.
module tb_keycode_move_ctrl;

  localparam int S    = 16;
  localparam int AF   = 12;
  localparam int CF   = 8;
  localparam int STP  = 3;
  localparam int XMIN = 0;
  localparam int XMAX = 62;
  localparam int YMIN = 2;
  localparam int YMAX = 50;
  localparam int XI   = 32;
  localparam int YI   = 25;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] keycode;
  logic       frame_tick;
  logic [9:0] player_x, player_y;
  logic [1:0] facing;
  logic       walking, attack_active, attack_start;
`ifdef KEYCODE_DIAG_EN
  logic [15:0] diag;
`endif

  keycode_move_ctrl #(
    .STABLE_CYCLES(S), .ATTACK_FRAMES(AF), .COOLDOWN_FRAMES(CF), .STEP(STP),
    .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX), .X_INIT(XI), .Y_INIT(YI)
  ) u_dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .keycode       (keycode),
    .frame_tick    (frame_tick),
    .player_x      (player_x),
    .player_y      (player_y),
    .facing        (facing),
    .walking       (walking),
    .attack_active (attack_active),
    .attack_start  (attack_start)
`ifdef KEYCODE_DIAG_EN
    ,
    .diag          (diag)
`endif
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int atk_ticks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                              tag, got, got, exp, exp, $time);
    else n_pass++;
  endtask

  // Reference model: mode 0 idle, 1 walk, 2 attack, 3 cooldown; m_left = ticks still to go.
  int         m_mode, m_left, m_x, m_y, m_face, m_run;
  logic [7:0] m_key, m_prev, m_last;
  bit         m_start;

  function automatic int dir_of(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h16:   return 1;
      8'h04:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_update(input logic [7:0] kc, input logic tk, input logic rn);
    bit rise;
    int d;
    if (!rn) begin
      m_key = 8'h00; m_prev = 8'h00; m_last = 8'h00; m_run = 1;
      m_mode = 0; m_left = 0; m_x = XI; m_y = YI; m_face = 1; m_start = 0;
      return;
    end
    rise    = (m_key == 8'h2C) && (m_prev != 8'h2C);
    d       = dir_of(m_key);
    m_start = 0;
    case (m_mode)
      0: begin
        if (rise) begin m_mode = 2; m_left = AF; m_start = 1; end
        else if (d >= 0) begin m_mode = 1; m_face = d; end
      end
      1: begin
        if (rise) begin m_mode = 2; m_left = AF; m_start = 1; end
        else if (d < 0) m_mode = 0;
        else begin
          m_face = d;
          if (tk) begin
            case (d)
              0: m_y = (m_y - STP < YMIN) ? YMIN : m_y - STP;
              1: m_y = (m_y + STP > YMAX) ? YMAX : m_y + STP;
              2: m_x = (m_x - STP < XMIN) ? XMIN : m_x - STP;
              default: m_x = (m_x + STP > XMAX) ? XMAX : m_x + STP;
            endcase
          end
        end
      end
      2: if (tk) begin
        m_left--;
        if (m_left == 0) begin m_mode = 3; m_left = CF; end
      end
      default: if (tk) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
    // A value is accepted after S+1 consecutive identical samples.
    m_prev = m_key;
    if (kc == m_last) m_run++;
    else begin m_last = kc; m_run = 1; end
    if (m_run >= S + 1) m_key = kc;
  endtask

  task automatic compare_all();
    check_eq("player_x", 32'(player_x), 32'(m_x));
    check_eq("player_y", 32'(player_y), 32'(m_y));
    check_eq("facing", 32'(facing), 32'(m_face));
    check_eq("walking", 32'(walking), 32'(m_mode == 1));
    check_eq("attack_active", 32'(attack_active), 32'(m_mode == 2));
    check_eq("attack_start", 32'(attack_start), 32'(m_start));
`ifdef KEYCODE_DIAG_EN
    check_eq("diag", 32'(diag), {16'd0, 6'((m_mode == 2) ? AF - m_left :
                                          (m_mode == 3) ? CF - m_left : 0),
                                 2'(m_mode), m_key});
`endif
  endtask

  task automatic step(input logic [7:0] kc, input logic tk, input logic rn);
    keycode = kc; frame_tick = tk; reset_reset_n = rn;
    if (rn && tk && attack_active === 1'b1) atk_ticks++;
    @(posedge clk_clk);
    model_update(kc, tk, rn);
    @(negedge clk_clk);
    compare_all();
    if (attack_start === 1'b1) n_start++;
  endtask

  // per == 0: no ticks; otherwise a tick every per cycles.
  task automatic hold(input logic [7:0] kc, input int n, input int per);
    for (int i = 0; i < n; i++) step(kc, (per != 0) && (i % per == per - 1), 1'b1);
  endtask

  logic [7:0] kc_tab [6];

  initial begin
    kc_tab[0] = 8'h1A; kc_tab[1] = 8'h16; kc_tab[2] = 8'h04;
    kc_tab[3] = 8'h07; kc_tab[4] = 8'h2C; kc_tab[5] = 8'h00;
    keycode = 8'h00; frame_tick = 1'b0; reset_reset_n = 1'b0;

    step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    check_eq("reset_x", 32'(player_x), 32'(XI));
    check_eq("reset_facing", 32'(facing), 32'd1);

    // Walk right: 20 cycles to accept, then 5 ticks.
    hold(8'h07, 20, 0);
    hold(8'h07, 10, 2);
    check_eq("walk_walking", 32'(walking), 32'd1);
    check_eq("walk_facing", 32'(facing), 32'd3);
    check_eq("walk_x", 32'(player_x), 32'(XI + 5 * STP));
    check_eq("walk_y", 32'(player_y), 32'(YI));

    // Glitching keycode never gets accepted.
    hold(8'h00, 20, 0);
    for (int r = 0; r < 6; r++) begin
      hold(8'h1A, 4, 2);
      hold(8'h00, 4, 2);
    end
    check_eq("glitch_walking", 32'(walking), 32'd0);
    check_eq("glitch_y", 32'(player_y), 32'(YI));
    check_eq("glitch_x", 32'(player_x), 32'(XI + 5 * STP));

    // Clamp at both X bounds.
    hold(8'h04, 20, 0);
    hold(8'h04, 40, 2);
    check_eq("clamp_left", 32'(player_x), 32'(XMIN));
    hold(8'h07, 20, 0);
    hold(8'h07, 60, 2);
    check_eq("clamp_right", 32'(player_x), 32'(XMAX));

    // Attack from walk with held space: one pulse, 12 ticks of attack, no retrigger.
    n_start = 0; atk_ticks = 0;
    hold(8'h2C, 150, 4);
    check_eq("atk_pulses", 32'(n_start), 32'd1);
    check_eq("atk_ticks", 32'(atk_ticks), 32'(AF));
    check_eq("atk_done_active", 32'(attack_active), 32'd0);
    check_eq("atk_done_walk", 32'(walking), 32'd0);
    check_eq("atk_x_frozen", 32'(player_x), 32'(XMAX));

    // Reset during attack.
    hold(8'h00, 20, 0);
    hold(8'h2C, 22, 0);
    check_eq("pre_rst_active", 32'(attack_active), 32'd1);
    step(8'h2C, 1'b0, 1'b0);
    check_eq("rst_x", 32'(player_x), 32'(XI));
    check_eq("rst_y", 32'(player_y), 32'(YI));
    check_eq("rst_facing", 32'(facing), 32'd1);
    check_eq("rst_active", 32'(attack_active), 32'd0);
    check_eq("rst_start", 32'(attack_start), 32'd0);

`ifdef KEYCODE_DIAG_EN
    hold(8'h16, 20, 0);
    check_eq("diag_key", 32'(diag[7:0]), 32'h16);
    check_eq("diag_state", 32'(diag[9:8]), 32'd1);
`endif

    // Random phase.
    for (int seg = 0; seg < 160; seg++) begin
      int         sel, len;
      logic [7:0] kc;
      sel = $urandom_range(0, 7);
      kc  = (sel < 6) ? kc_tab[sel] : 8'($urandom_range(0, 255));
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++)
        step(kc, ($urandom_range(0, 2) == 0), ($urandom_range(0, 399) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keycode_move_ctrl.md
# keycode_move_ctrl

Converts the 8-bit USB HID keycode exported by the NIOS II SoC into player-motion state for the Zelda game. Sits directly downstream of the SoC `keycode_export` port and upstream of the sprite/VGA renderer. Filters keycode glitches, runs a walk/attack state machine paced by the frame tick, and maintains clamped player X/Y coordinates.

## Interface
- `STABLE_CYCLES`, 16: consecutive identical samples required before a keycode is accepted (≥1)
- `ATTACK_FRAMES`, 12: frame ticks spent in ATTACK
- `COOLDOWN_FRAMES`, 8: frame ticks spent in COOLDOWN
- `STEP`, 1: pixels moved per frame tick while walking
- `X_MIN`, 0 / `X_MAX`, 624 / `Y_MIN`, 0 / `Y_MAX`, 464: inclusive position bounds
- `X_INIT`, 320 / `Y_INIT`, 240: reset position
- `clk_clk` in 1: system clock, same clock as the SoC
- `reset_reset_n` in 1: synchronous, active-low reset
- `keycode` in 8: from SoC `keycode_export`; unregistered, may change on any cycle
- `frame_tick` in 1: one-cycle pulse per video frame (from VGA controller, vsync start)
- `player_x` out 10: current X, reset `X_INIT`
- `player_y` out 10: current Y, reset `Y_INIT`
- `facing` out 2: 0 up, 1 down, 2 left, 3 right; reset 1
- `walking` out 1: high in WALK; reset 0
- `attack_active` out 1: high in ATTACK; reset 0
- `attack_start` out 1: one-cycle pulse on entry to ATTACK; reset 0
- `diag` out 16: present only with `KEYCODE_DIAG_EN`

## Operation
- Filter: registers `cand` (8b, reset 0x00), `cnt`, `key_q` (reset 0x00). If `keycode != cand`: `cand<=keycode`, `cnt<=0`. Else if `cnt == STABLE_CYCLES-1`: `key_q<=cand`. Else `cnt<=cnt+1`. Net effect: a new value is accepted into `key_q` once it has been sampled unchanged on STABLE_CYCLES+1 consecutive edges.
- Decode `key_q`: 0x1A (W) up, 0x16 (S) down, 0x04 (A) left, 0x07 (D) right, 0x2C (space) attack; all other values = none.
- `atk_rise`: `key_q` equals 0x2C and previous-cycle `key_q` did not.
- FSM states IDLE, WALK, ATTACK, COOLDOWN; frame counter `fcnt` cleared on every state entry.
  - IDLE: `atk_rise` -> ATTACK; else direction key -> WALK, `facing<=dir`.
  - WALK: `atk_rise` -> ATTACK (no move that cycle); else key none/non-direction -> IDLE; else `facing<=dir`, and on `frame_tick` move STEP in `dir`.
  - ATTACK: count `frame_tick`; at ATTACK_FRAMES-th tick -> COOLDOWN. Position and facing frozen.
  - COOLDOWN: count `frame_tick`; at COOLDOWN_FRAMES-th tick -> IDLE. Keys ignored; held space never retriggers (edge required).
- Movement arithmetic in 11 bits, then clamped: up `y = (y < Y_MIN+STEP) ? Y_MIN : y-STEP`; down `y = (y+STEP > Y_MAX) ? Y_MAX : y+STEP`; left/right same on X. Never wraps.
- Attack has priority over direction. Only one direction per keycode; no diagonals.

## Timing
- All outputs registered. `walking`/`attack_active` reflect the state register.
- `key_q` change -> state change: next edge (1 cycle). Keycode change -> `key_q`: STABLE_CYCLES+1 edges if stable.
- Position updates on the edge that samples `frame_tick` in WALK; visible the following cycle.
- `frame_tick` in the same cycle as IDLE->WALK: no move. `frame_tick` in the same cycle as ATTACK entry: not counted.
- Reset mid-operation (any state): all registers return to reset values on the next edge; `attack_start` cleared.

## Configuration
- `KEYCODE_DIAG_EN` defined: `diag` port exists; `diag[7:0]=key_q`, `diag[9:8]`=state (0 IDLE,1 WALK,2 ATTACK,3 COOLDOWN), `diag[15:10]=fcnt[5:0]`; reset 0x0000; intended for `hex_digits`.
- Undefined: no `diag` port, no extra logic; functional behaviour identical.

## Test plan
- Reset, hold `keycode`=0x07 for 20 cycles then 5 frame_ticks -> `walking`=1, `facing`=3, `player_x`=325, `player_y`=240.
- `keycode` toggles 0x1A/0x00 every 4 cycles (STABLE_CYCLES=16) -> `key_q` stays 0x00, position unchanged, `walking`=0.
- Hold 0x04 from X=2 with STEP=3, 2 frame_ticks -> `player_x`=0 then stays 0; hold 0x07 at X=623 -> 624 and holds.
- Walking right, switch to 0x2C -> one `attack_start` pulse, `attack_active` for exactly 12 frame_ticks, then COOLDOWN 8 ticks, then IDLE; held space does not retrigger.
- Assert `reset_reset_n`=0 for one cycle during ATTACK -> next cycle all outputs at reset values (X=320, Y=240, facing=1).
- With `KEYCODE_DIAG_EN`, hold 0x16 -> `diag[7:0]`=0x16, `diag[9:8]`=1.
